// File: rtl/con_pkg.sv
// Shared definitions for the con_seq control sequencer.
//   opcode_e : instruction opcodes held in ir[IW-1:IW-4]
//   state_e  : sequencer states
//   S_*      : encodings of the memory address-source select s
package con_pkg;

    typedef enum logic [3:0] {
        OP_MOVA  = 4'd0,
        OP_MOVB  = 4'd1,
        OP_MOVC  = 4'd2,
        OP_MOVD  = 4'd3,
        OP_ADD   = 4'd4,
        OP_SUB   = 4'd5,
        OP_JMP   = 4'd6,
        OP_JG    = 4'd7,
        OP_IN    = 4'd8,
        OP_OUT   = 4'd9,
        OP_MOVI  = 4'd10,
        OP_HALT  = 4'd11,
        OP_NOP12 = 4'd12,
        OP_NOP13 = 4'd13,
        OP_NOP14 = 4'd14,
        OP_NOP15 = 4'd15
    } opcode_e;

    typedef enum logic [2:0] {
        ST_FETCH,
        ST_DECODE,
        ST_EXEC,
        ST_MEM,
        ST_IOWAIT,
        ST_PAUSE,
        ST_HALT
    } state_e;

    localparam logic [1:0] S_PC = 2'b00;
    localparam logic [1:0] S_SR = 2'b01;
    localparam logic [1:0] S_DR = 2'b10;

endpackage

// File: rtl/con_cnt.sv
// Retired-instruction counter.
//   clk, rst : clock and synchronous active-high reset
//   inc      : advance by one this cycle (wraps at 2^CW-1)
//   q        : current count
module con_cnt #(
    parameter int unsigned CW = 16
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          inc,
    output logic [CW-1:0] q
);

    always_ff @(posedge clk) begin
        if (rst)
            q <= '0;
        else if (inc)
            q <= q + CW'(1);
    end

endmodule

// File: rtl/con_seq.sv
// Control sequencer for a small accumulator-style datapath.
//   clk, rst            : clock, synchronous active-high reset
//   ram_dout, ram_rdy   : memory read data / access complete
//   in_vld              : input device data valid
//   g                   : greater flag
//   step_mode, step     : single-step enable and step pulse
//   ir                  : latched instruction
//   ir_ld .. mux_s      : datapath strobes
//   reg_sr, reg_dr      : register addresses from ir
//   s                   : address source (PC / reg_sr / reg_dr)
//   au_ac               : ALU opcode (ir top nibble)
//   halted              : sequencer is in HALT
//   instr_cnt           : retired-instruction count
module con_seq
    import con_pkg::*;
#(
    parameter int unsigned IW  = 8,
    parameter int unsigned RAW = 2,
    parameter int unsigned CW  = 16
) (
    input  logic           clk,
    input  logic           rst,
    input  logic [IW-1:0]  ram_dout,
    input  logic           ram_rdy,
    input  logic           in_vld,
    input  logic           g,
    input  logic           step_mode,
    input  logic           step,
    output logic [IW-1:0]  ir,
    output logic           ir_ld,
    output logic           ram_re,
    output logic           ram_wr,
    output logic           pc_ld,
    output logic           pc_inc,
    output logic           reg_we,
    output logic           au_en,
    output logic           gf_en,
    output logic           in_en,
    output logic           out_en,
    output logic           mux_s,
    output logic [RAW-1:0] reg_sr,
    output logic [RAW-1:0] reg_dr,
    output logic [1:0]     s,
    output logic [3:0]     au_ac,
    output logic           halted,
    output logic [CW-1:0]  instr_cnt
);

    state_e        state;
    logic [IW-1:0] ir_q;
    opcode_e       op;
    logic          rdy_ok;
    logic          vld_ok;
    logic          retire;

    assign op     = opcode_e'(ir_q[IW-1:IW-4]);
    assign ir     = ir_q;
    assign au_ac  = ir_q[IW-1:IW-4];
    assign reg_sr = ir_q[RAW-1:0];
    assign reg_dr = ir_q[2*RAW-1:RAW];
    assign halted = (state == ST_HALT);

    // A handshake arriving in a reset cycle is discarded so that an
    // interrupted MEM/IOWAIT/FETCH never emits its completion pulses.
    assign rdy_ok = ram_rdy & ~rst;
    assign vld_ok = in_vld & ~rst;

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= ST_FETCH;
            ir_q  <= '0;
        end else begin
            case (state)
                ST_FETCH: begin
                    if (ram_rdy) begin
                        ir_q  <= ram_dout;
                        state <= ST_DECODE;
                    end
                end
                ST_DECODE: begin
                    case (op)
                        OP_MOVB, OP_MOVC, OP_MOVI: state <= ST_MEM;
                        OP_IN:                     state <= ST_IOWAIT;
                        OP_HALT:                   state <= ST_HALT;
                        default:                   state <= ST_EXEC;
                    endcase
                end
                ST_EXEC:   state <= step_mode ? ST_PAUSE : ST_FETCH;
                ST_MEM:    if (ram_rdy) state <= step_mode ? ST_PAUSE : ST_FETCH;
                ST_IOWAIT: if (in_vld)  state <= step_mode ? ST_PAUSE : ST_FETCH;
                ST_PAUSE:  if (step || !step_mode) state <= ST_FETCH;
                ST_HALT:   state <= ST_HALT;
                default:   state <= ST_FETCH;
            endcase
        end
    end

    always_comb begin
        ir_ld  = 1'b0;
        ram_re = 1'b0;
        ram_wr = 1'b0;
        pc_ld  = 1'b0;
        pc_inc = 1'b0;
        reg_we = 1'b0;
        au_en  = 1'b0;
        gf_en  = 1'b0;
        in_en  = 1'b0;
        out_en = 1'b0;
        mux_s  = 1'b0;
        s      = S_PC;
        retire = 1'b0;
        case (state)
            ST_FETCH: begin
                ram_re = 1'b1;
                ir_ld  = rdy_ok;
                pc_inc = rdy_ok;
            end
            ST_DECODE: retire = (op == OP_HALT) & ~rst;
            ST_EXEC: begin
                retire = ~rst;
                case (op)
                    OP_MOVA: begin reg_we = 1'b1; au_en = 1'b1; mux_s = 1'b1; end
                    OP_MOVD: reg_we = 1'b1;
                    OP_ADD:  begin reg_we = 1'b1; au_en = 1'b1; mux_s = 1'b1; end
                    OP_SUB:  begin reg_we = 1'b1; au_en = 1'b1; mux_s = 1'b1; gf_en = 1'b1; end
                    OP_OUT:  begin au_en = 1'b1; out_en = 1'b1; end
                    OP_JMP:  pc_ld = 1'b1;
                    OP_JG:   pc_ld = g;
                    default: ;
                endcase
            end
            ST_MEM: begin
                retire = rdy_ok;
                case (op)
                    OP_MOVB: begin ram_wr = 1'b1; s = S_DR; au_en = 1'b1; end
                    OP_MOVC: begin
                        ram_re = 1'b1;
                        s      = S_SR;
                        reg_we = rdy_ok;
                        mux_s  = rdy_ok;
                    end
                    OP_MOVI: begin
                        ram_re = 1'b1;
                        reg_we = rdy_ok;
                        mux_s  = rdy_ok;
                        pc_inc = rdy_ok;
                    end
                    default: ;
                endcase
            end
            ST_IOWAIT: begin
                in_en  = 1'b1;
                reg_we = vld_ok;
                mux_s  = vld_ok;
                retire = vld_ok;
            end
            default: ;
        endcase
    end

    con_cnt #(.CW(CW)) u_cnt (
        .clk (clk),
        .rst (rst),
        .inc (retire),
        .q   (instr_cnt)
    );

endmodule

// File: tb/tb_con_seq.sv
module tb_con_seq;

    logic       clk;
    logic       rst;
    logic [7:0] ram_dout;
    logic       ram_rdy, in_vld, g, step_mode, step;
    logic [7:0] ir;
    logic       ir_ld, ram_re, ram_wr, pc_ld, pc_inc, reg_we, au_en, gf_en, in_en, out_en, mux_s;
    logic [1:0] reg_sr, reg_dr, s;
    logic [3:0] au_ac;
    logic       halted;
    logic [15:0] instr_cnt;

    // second instance with a 2-bit counter for the wrap scenario
    logic [7:0] d2_ir;
    logic       d2_ir_ld, d2_ram_re, d2_ram_wr, d2_pc_ld, d2_pc_inc, d2_reg_we;
    logic       d2_au_en, d2_gf_en, d2_in_en, d2_out_en, d2_mux_s, d2_halted;
    logic [1:0] d2_reg_sr, d2_reg_dr, d2_s, d2_instr_cnt;
    logic [3:0] d2_au_ac;

    int checks;
    int errors;

    localparam logic [10:0] IRLD  = 11'b100_0000_0000;
    localparam logic [10:0] RE    = 11'b010_0000_0000;
    localparam logic [10:0] WR    = 11'b001_0000_0000;
    localparam logic [10:0] PCLD  = 11'b000_1000_0000;
    localparam logic [10:0] PCINC = 11'b000_0100_0000;
    localparam logic [10:0] REGWE = 11'b000_0010_0000;
    localparam logic [10:0] AUEN  = 11'b000_0001_0000;
    localparam logic [10:0] GFEN  = 11'b000_0000_1000;
    localparam logic [10:0] INEN  = 11'b000_0000_0100;
    localparam logic [10:0] OUTEN = 11'b000_0000_0010;
    localparam logic [10:0] MUXS  = 11'b000_0000_0001;

    logic [10:0] strobes;
    assign strobes = {ir_ld, ram_re, ram_wr, pc_ld, pc_inc, reg_we, au_en, gf_en, in_en, out_en, mux_s};

    con_seq #(.IW(8), .RAW(2), .CW(16)) dut (
        .clk(clk), .rst(rst), .ram_dout(ram_dout), .ram_rdy(ram_rdy), .in_vld(in_vld),
        .g(g), .step_mode(step_mode), .step(step), .ir(ir), .ir_ld(ir_ld),
        .ram_re(ram_re), .ram_wr(ram_wr), .pc_ld(pc_ld), .pc_inc(pc_inc),
        .reg_we(reg_we), .au_en(au_en), .gf_en(gf_en), .in_en(in_en),
        .out_en(out_en), .mux_s(mux_s), .reg_sr(reg_sr), .reg_dr(reg_dr),
        .s(s), .au_ac(au_ac), .halted(halted), .instr_cnt(instr_cnt)
    );

    con_seq #(.IW(8), .RAW(2), .CW(2)) dut2 (
        .clk(clk), .rst(rst), .ram_dout(ram_dout), .ram_rdy(ram_rdy), .in_vld(in_vld),
        .g(g), .step_mode(step_mode), .step(step), .ir(d2_ir), .ir_ld(d2_ir_ld),
        .ram_re(d2_ram_re), .ram_wr(d2_ram_wr), .pc_ld(d2_pc_ld), .pc_inc(d2_pc_inc),
        .reg_we(d2_reg_we), .au_en(d2_au_en), .gf_en(d2_gf_en), .in_en(d2_in_en),
        .out_en(d2_out_en), .mux_s(d2_mux_s), .reg_sr(d2_reg_sr), .reg_dr(d2_reg_dr),
        .s(d2_s), .au_ac(d2_au_ac), .halted(d2_halted), .instr_cnt(d2_instr_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // advance to just after the next rising edge
    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1; ram_rdy = 1'b0; in_vld = 1'b0; step = 1'b0; g = 1'b0;
        cyc();
        rst = 1'b0;
    endtask

    // FETCH with immediate ram_rdy, then DECODE; returns in the following state
    task automatic fetch(input logic [7:0] instr);
        ram_dout = instr; ram_rdy = 1'b1;
        #1;
        checks++; if (strobes !== (IRLD | RE | PCINC) || s !== 2'b00) begin
            errors++; $display("FAIL fetch_%h: strobes=%b s=%b expected %b s=00", instr, strobes, s, IRLD | RE | PCINC); end
        cyc();
        ram_rdy = 1'b0;
        #1;
        checks++; if (strobes !== 11'b0 || ir !== instr) begin
            errors++; $display("FAIL decode_%h: strobes=%b ir=%h expected 0 ir=%h", instr, strobes, ir, instr); end
        cyc();
    endtask

    task automatic test_reset();
        rst = 1'b1; ram_rdy = 1'b1; ram_dout = 8'hB0; in_vld = 1'b0; g = 1'b0; step_mode = 1'b0; step = 1'b0;
        cyc(); cyc();
        rst = 1'b0; ram_rdy = 1'b0;
        #1;
        checks++; if (strobes !== RE || s !== 2'b00 || halted !== 1'b0) begin
            errors++; $display("FAIL reset_strobes: strobes=%b s=%b halted=%b expected %b s=00 halted=0", strobes, s, halted, RE); end
        checks++; if (ir !== 8'h00 || au_ac !== 4'h0 || reg_sr !== 2'd0 || reg_dr !== 2'd0 || instr_cnt !== 16'd0) begin
            errors++; $display("FAIL reset_regs: ir=%h au_ac=%h sr=%0d dr=%0d cnt=%0d expected all 0", ir, au_ac, reg_sr, reg_dr, instr_cnt); end
        // FETCH holds while ram_rdy is low
        cyc(); #1;
        checks++; if (strobes !== RE || ir !== 8'h00) begin
            errors++; $display("FAIL fetch_hold: strobes=%b ir=%h expected %b ir=00", strobes, ir, RE); end
    endtask

    task automatic test_add();
        do_reset();
        fetch(8'h46);
        #1;
        checks++; if (strobes !== (REGWE | AUEN | MUXS)) begin
            errors++; $display("FAIL add_exec: strobes=%b expected %b", strobes, REGWE | AUEN | MUXS); end
        checks++; if (au_ac !== 4'd4 || reg_dr !== 2'd1 || reg_sr !== 2'd2) begin
            errors++; $display("FAIL add_fields: au_ac=%0d dr=%0d sr=%0d expected 4 1 2", au_ac, reg_dr, reg_sr); end
        cyc(); #1;
        checks++; if (instr_cnt !== 16'd1 || strobes !== RE) begin
            errors++; $display("FAIL add_retire: cnt=%0d strobes=%b expected 1 %b", instr_cnt, strobes, RE); end
    endtask

    task automatic test_jg();
        do_reset();
        g = 1'b0;
        fetch(8'h70);
        #1;
        checks++; if (strobes !== 11'b0) begin
            errors++; $display("FAIL jg_g0: strobes=%b expected 0", strobes); end
        cyc();
        g = 1'b1;
        fetch(8'h70);
        #1;
        checks++; if (strobes !== PCLD) begin
            errors++; $display("FAIL jg_g1: strobes=%b expected %b", strobes, PCLD); end
        cyc(); g = 1'b0; #1;
        checks++; if (instr_cnt !== 16'd2) begin
            errors++; $display("FAIL jg_cnt: cnt=%0d expected 2", instr_cnt); end
    endtask

    task automatic test_movc_wait();
        do_reset();
        fetch(8'h21);
        for (int i = 0; i < 3; i++) begin
            #1;
            checks++; if (strobes !== RE || s !== 2'b01) begin
                errors++; $display("FAIL movc_wait%0d: strobes=%b s=%b expected %b s=01", i, strobes, s, RE); end
            cyc();
        end
        ram_rdy = 1'b1; #1;
        checks++; if (strobes !== (RE | REGWE | MUXS) || s !== 2'b01) begin
            errors++; $display("FAIL movc_rdy: strobes=%b s=%b expected %b s=01", strobes, s, RE | REGWE | MUXS); end
        cyc(); ram_rdy = 1'b0; #1;
        checks++; if (strobes !== RE || s !== 2'b00 || instr_cnt !== 16'd1) begin
            errors++; $display("FAIL movc_done: strobes=%b s=%b cnt=%0d expected %b s=00 cnt=1", strobes, s, instr_cnt, RE); end
    endtask

    task automatic test_movb_movi();
        do_reset();
        fetch(8'h19);
        #1;
        checks++; if (strobes !== (WR | AUEN) || s !== 2'b10) begin
            errors++; $display("FAIL movb_wait: strobes=%b s=%b expected %b s=10", strobes, s, WR | AUEN); end
        cyc(); ram_rdy = 1'b1; #1;
        checks++; if (strobes !== (WR | AUEN) || s !== 2'b10) begin
            errors++; $display("FAIL movb_rdy: strobes=%b s=%b expected %b s=10", strobes, s, WR | AUEN); end
        cyc(); ram_rdy = 1'b0;
        fetch(8'hA4);
        #1;
        checks++; if (strobes !== RE || s !== 2'b00) begin
            errors++; $display("FAIL movi_wait: strobes=%b s=%b expected %b s=00", strobes, s, RE); end
        cyc(); ram_rdy = 1'b1; #1;
        checks++; if (strobes !== (RE | REGWE | MUXS | PCINC) || s !== 2'b00) begin
            errors++; $display("FAIL movi_rdy: strobes=%b s=%b expected %b s=00", strobes, s, RE | REGWE | MUXS | PCINC); end
        cyc(); ram_rdy = 1'b0; #1;
        checks++; if (instr_cnt !== 16'd2 || strobes !== RE) begin
            errors++; $display("FAIL movb_movi_cnt: cnt=%0d strobes=%b expected 2 %b", instr_cnt, strobes, RE); end
    endtask

    task automatic test_in_reset();
        do_reset();
        fetch(8'h84);
        for (int i = 0; i < 2; i++) begin
            #1;
            checks++; if (strobes !== INEN) begin
                errors++; $display("FAIL in_wait%0d: strobes=%b expected %b", i, strobes, INEN); end
            cyc();
        end
        rst = 1'b1; #1;
        checks++; if ((strobes & (REGWE | PCINC)) !== 11'b0) begin
            errors++; $display("FAIL in_rst_pulse: strobes=%b expected no reg_we/pc_inc", strobes); end
        cyc(); rst = 1'b0; #1;
        checks++; if (strobes !== RE || instr_cnt !== 16'd0 || ir !== 8'h00) begin
            errors++; $display("FAIL in_rst_fetch: strobes=%b cnt=%0d ir=%h expected %b 0 00", strobes, instr_cnt, ir, RE); end
    endtask

    task automatic test_step();
        do_reset();
        step_mode = 1'b1;
        fetch(8'hC0);
        #1;
        checks++; if (strobes !== 11'b0) begin
            errors++; $display("FAIL nop1_exec: strobes=%b expected 0", strobes); end
        cyc();
        for (int i = 0; i < 2; i++) begin
            #1;
            checks++; if (strobes !== 11'b0 || instr_cnt !== 16'd1) begin
                errors++; $display("FAIL pause1_%0d: strobes=%b cnt=%0d expected 0 1", i, strobes, instr_cnt); end
            cyc();
        end
        step = 1'b1; #1;
        checks++; if (strobes !== 11'b0) begin
            errors++; $display("FAIL pause1_step: strobes=%b expected 0", strobes); end
        cyc(); step = 1'b0; #1;
        checks++; if (strobes !== RE) begin
            errors++; $display("FAIL step_fetch: strobes=%b expected %b", strobes, RE); end
        fetch(8'hD0);
        cyc(); #1;
        checks++; if (strobes !== 11'b0 || instr_cnt !== 16'd2) begin
            errors++; $display("FAIL pause2: strobes=%b cnt=%0d expected 0 2", strobes, instr_cnt); end
        // leaving single-step mode releases PAUSE without a step pulse
        step_mode = 1'b0;
        cyc(); #1;
        checks++; if (strobes !== RE || instr_cnt !== 16'd2) begin
            errors++; $display("FAIL pause_release: strobes=%b cnt=%0d expected %b 2", strobes, instr_cnt, RE); end
    endtask

    task automatic test_wrap_halt();
        logic [7:0]  prog [5];
        logic [10:0] exp  [5];
        prog[0] = 8'h46; exp[0] = REGWE | AUEN | MUXS;
        prog[1] = 8'h51; exp[1] = REGWE | AUEN | MUXS | GFEN;
        prog[2] = 8'h60; exp[2] = PCLD;
        prog[3] = 8'h90; exp[3] = AUEN | OUTEN;
        prog[4] = 8'h0B; exp[4] = REGWE | AUEN | MUXS;
        do_reset();
        for (int i = 0; i < 5; i++) begin
            fetch(prog[i]);
            #1;
            checks++; if (strobes !== exp[i]) begin
                errors++; $display("FAIL wrap_exec%0d: strobes=%b expected %b", i, strobes, exp[i]); end
            cyc();
        end
        #1;
        checks++; if (d2_instr_cnt !== 2'd1 || instr_cnt !== 16'd5) begin
            errors++; $display("FAIL wrap_cnt: cw2=%0d cw16=%0d expected 1 5", d2_instr_cnt, instr_cnt); end
        fetch(8'hB0);
        #1;
        checks++; if (halted !== 1'b1 || d2_halted !== 1'b1 || d2_instr_cnt !== 2'd2 || instr_cnt !== 16'd6) begin
            errors++; $display("FAIL halt_entry: halted=%b cw2=%0d cw16=%0d expected 1 2 6", halted, d2_instr_cnt, instr_cnt); end
        ram_rdy = 1'b1; in_vld = 1'b1; step = 1'b1; g = 1'b1;
        for (int i = 0; i < 10; i++) begin
            cyc();
            checks++; if (halted !== 1'b1 || strobes !== 11'b0 || d2_instr_cnt !== 2'd2 || instr_cnt !== 16'd6) begin
                errors++; $display("FAIL halt_hold%0d: halted=%b strobes=%b cnt=%0d expected 1 0 6", i, halted, strobes, instr_cnt); end
        end
        ram_rdy = 1'b0; in_vld = 1'b0; step = 1'b0; g = 1'b0;
        do_reset(); #1;
        checks++; if (halted !== 1'b0 || strobes !== RE || instr_cnt !== 16'd0) begin
            errors++; $display("FAIL halt_exit: halted=%b strobes=%b cnt=%0d expected 0 %b 0", halted, strobes, instr_cnt, RE); end
    endtask

    initial begin
        checks = 0;
        errors = 0;
        rst = 1'b1; ram_dout = 8'h00; ram_rdy = 1'b0; in_vld = 1'b0;
        g = 1'b0; step_mode = 1'b0; step = 1'b0;
        test_reset();
        test_add();
        test_jg();
        test_movc_wait();
        test_movb_movi();
        test_in_reset();
        test_step();
        test_wrap_halt();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
